// File: rtl/onehot_to_binary_pkg.sv
// Shared widths, FSM state encoding and one-hot decode helpers for the
// one-hot to binary keypad-style encoder.
package onehot_to_binary_pkg;

  localparam int ONEHOT_W = 10;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUAL,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  typedef logic [ONEHOT_W-1:0] onehot_t;
  typedef logic [CODE_W-1:0]   code_t;

  // Highest set bit wins; only meaningful once is_onehot() has confirmed a single bit.
  function automatic code_t onehot_index(input onehot_t v);
    code_t idx;
    idx = '0;
    for (int k = 0; k < ONEHOT_W; k++) begin
      if (v[k]) idx = code_t'(k);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input onehot_t v);
    int ones;
    ones = 0;
    for (int k = 0; k < ONEHOT_W; k++) begin
      if (v[k]) ones = ones + 1;
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/onehot_to_binary_sync_2ff.sv
// Two-flop synchronizer bringing asynchronous select lines into the clk domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/onehot_to_binary.sv
// Debounced one-hot to binary encoder: a pattern must stay stable for
// STABLE_CYCLES synchronized samples, then emits one code or one rejection.
module onehot_to_binary
  import onehot_to_binary_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ONEHOT_W-1:0] onehot_in,
  output logic [CODE_W-1:0]   code_out,
  output logic                code_valid,
  input  logic                code_ready,
  output logic                invalid_pulse,
  output logic [7:0]          err_count
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  onehot_t w_s2;
  code_t   w_idx;
  logic    w_isOnehot;

  state_t  r_state;
  logic [7:0] r_cnt;
  onehot_t r_cap;
  code_t   r_code;
  logic    r_valid;
  logic    r_invalid;
  logic [7:0] r_err;

  sync_2ff #(.W(ONEHOT_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (onehot_in),
    .o_q   (w_s2)
  );

  assign w_idx      = onehot_index(r_cap);
  assign w_isOnehot = is_onehot(r_cap);

  // A new nonzero pattern restarts qualification; after a decision the FSM
  // parks in RELEASE until the lines go idle so a held input fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cap     <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_invalid <= 1'b0;
      r_err     <= '0;
    end else begin
      r_invalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s2 != '0) begin
            r_state <= ST_QUAL;
            r_cap   <= w_s2;
            r_cnt   <= 8'd1;
          end
        end
        ST_QUAL: begin
          if (w_s2 == '0) begin
            r_state <= ST_IDLE;
          end else if (w_s2 != r_cap) begin
            r_cap <= w_s2;
            r_cnt <= 8'd1;
          end else if (r_cnt < CNT_LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (w_isOnehot) begin
            r_state <= ST_HOLD;
            r_code  <= w_idx;
            r_valid <= 1'b1;
          end else begin
            r_state   <= ST_RELEASE;
            r_invalid <= 1'b1;
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          end
        end
        ST_HOLD: begin
          if (code_ready) begin
            r_state <= ST_RELEASE;
            r_valid <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (w_s2 == '0) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign code_out      = r_code;
  assign code_valid    = r_valid;
  assign invalid_pulse = r_invalid;
  assign err_count     = r_err;

endmodule

// File: tb/tb_onehot_to_binary.sv
// Directed self-checking bench for onehot_to_binary at STABLE_CYCLES=4.
module tb_onehot_to_binary;

  logic       clk;
  logic       rst_n;
  logic [9:0] onehot_in;
  logic [3:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       invalid_pulse;
  logic [7:0] err_count;

  int compareCount  = 0;
  int mismatchCount = 0;

  onehot_to_binary #(.STABLE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .onehot_in     (onehot_in),
    .code_out      (code_out),
    .code_valid    (code_valid),
    .code_ready    (code_ready),
    .invalid_pulse (invalid_pulse),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle, so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    onehot_in = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    onehot_in  = 10'h3FF;
    code_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    compareCount++;
    if (code_valid !== 1'b0) begin
      mismatchCount++;
      $display("[TB] FAIL reset_valid: got %0b expected 0", code_valid);
    end
    compareCount++;
    if (code_out !== 4'd0) begin
      mismatchCount++;
      $display("[TB] FAIL reset_code: got %0d expected 0", code_out);
    end
    compareCount++;
    if (invalid_pulse !== 1'b0 || err_count !== 8'd0) begin
      mismatchCount++;
      $display("[TB] FAIL reset_err: got pulse=%0b cnt=%0d expected 0/0", invalid_pulse, err_count);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    onehot_in = '0;
    idleCycles(3);
  endtask

  task automatic test_latency();
    int extraValid;
    int extraInvalid;
    code_ready = 1'b1;
    onehot_in  = 10'h008;
    for (int e = 1; e <= 5; e++) begin
      tick();
      compareCount++;
      if (code_valid !== 1'b0) begin
        mismatchCount++;
        $display("[TB] FAIL latency_early_edge%0d: got valid=%0b expected 0", e, code_valid);
      end
    end
    tick();
    compareCount++;
    if (code_valid !== 1'b1 || code_out !== 4'd3) begin
      mismatchCount++;
      $display("[TB] FAIL latency_edge6: got valid=%0b code=%0d expected 1/3", code_valid, code_out);
    end
    tick();
    compareCount++;
    if (code_valid !== 1'b0) begin
      mismatchCount++;
      $display("[TB] FAIL latency_single_cycle: got valid=%0b expected 0", code_valid);
    end
    extraValid   = 0;
    extraInvalid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (code_valid)    extraValid++;
      if (invalid_pulse) extraInvalid++;
    end
    compareCount++;
    if (extraValid != 0 || extraInvalid != 0) begin
      mismatchCount++;
      $display("[TB] FAIL latency_held_no_repeat: got valid=%0d pulses=%0d expected 0/0", extraValid, extraInvalid);
    end
    compareCount++;
    if (code_out !== 4'd3) begin
      mismatchCount++;
      $display("[TB] FAIL latency_code_retained: got %0d expected 3", code_out);
    end
    idleCycles(4);
  endtask

  task automatic test_backpressure();
    int dropped;
    int badCode;
    int lateValid;
    code_ready = 1'b0;
    onehot_in  = 10'h200;
    for (int i = 0; i < 6; i++) tick();
    compareCount++;
    if (code_valid !== 1'b1 || code_out !== 4'd9) begin
      mismatchCount++;
      $display("[TB] FAIL bp_first_valid: got valid=%0b code=%0d expected 1/9", code_valid, code_out);
    end
    dropped = 0;
    badCode = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) onehot_in = 10'h001;
      if (i == 6) onehot_in = 10'h044;
      tick();
      if (code_valid !== 1'b1) dropped++;
      if (code_out !== 4'd9)   badCode++;
    end
    compareCount++;
    if (dropped != 0 || badCode != 0) begin
      mismatchCount++;
      $display("[TB] FAIL bp_hold_stable: got drops=%0d badcode=%0d expected 0/0", dropped, badCode);
    end
    onehot_in  = 10'h001;
    code_ready = 1'b1;
    tick();
    compareCount++;
    if (code_valid !== 1'b0) begin
      mismatchCount++;
      $display("[TB] FAIL bp_drop_after_accept: got valid=%0b expected 0", code_valid);
    end
    lateValid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (code_valid || invalid_pulse) lateValid++;
    end
    idleCycles(4);
    compareCount++;
    if (lateValid != 0 || code_out !== 4'd9) begin
      mismatchCount++;
      $display("[TB] FAIL bp_no_code_from_hold_input: got events=%0d code=%0d expected 0/9", lateValid, code_out);
    end
  endtask

  task automatic test_invalid();
    int pulses;
    int valids;
    code_ready = 1'b1;
    pulses     = 0;
    valids     = 0;
    onehot_in  = 10'h005;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (invalid_pulse) pulses++;
      if (code_valid)    valids++;
    end
    onehot_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (invalid_pulse) pulses++;
      if (code_valid)    valids++;
    end
    compareCount++;
    if (pulses != 1) begin
      mismatchCount++;
      $display("[TB] FAIL invalid_pulse_count: got %0d expected 1", pulses);
    end
    compareCount++;
    if (valids != 0) begin
      mismatchCount++;
      $display("[TB] FAIL invalid_no_valid: got %0d expected 0", valids);
    end
    compareCount++;
    if (err_count !== 8'd1) begin
      mismatchCount++;
      $display("[TB] FAIL invalid_err_count: got %0d expected 1", err_count);
    end
  endtask

  task automatic test_restart();
    int validCycles;
    int sawCode1;
    int pulses;
    logic [3:0] firstCode;
    code_ready  = 1'b1;
    validCycles = 0;
    sawCode1    = 0;
    pulses      = 0;
    firstCode   = 4'hF;
    onehot_in   = 10'h002;
    tick();
    tick();
    onehot_in = 10'h010;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (code_valid) begin
        validCycles++;
        if (firstCode == 4'hF) firstCode = code_out;
        if (code_out == 4'd1) sawCode1++;
      end
      if (invalid_pulse) pulses++;
    end
    idleCycles(4);
    compareCount++;
    if (validCycles != 1 || firstCode !== 4'd4) begin
      mismatchCount++;
      $display("[TB] FAIL restart_code: got cycles=%0d code=%0h expected 1/4", validCycles, firstCode);
    end
    compareCount++;
    if (sawCode1 != 0 || pulses != 0) begin
      mismatchCount++;
      $display("[TB] FAIL restart_no_code1: got code1=%0d pulses=%0d expected 0/0", sawCode1, pulses);
    end
  endtask

  task automatic test_reset_hold();
    code_ready = 1'b0;
    onehot_in  = 10'h080;
    for (int i = 0; i < 6; i++) tick();
    compareCount++;
    if (code_valid !== 1'b1 || code_out !== 4'd7) begin
      mismatchCount++;
      $display("[TB] FAIL rsthold_before: got valid=%0b code=%0d expected 1/7", code_valid, code_out);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    compareCount++;
    if (code_valid !== 1'b0 || code_out !== 4'd0 || err_count !== 8'd0) begin
      mismatchCount++;
      $display("[TB] FAIL rsthold_immediate: got valid=%0b code=%0d err=%0d expected 0/0/0", code_valid, code_out, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      compareCount++;
      if (code_valid !== 1'b0) begin
        mismatchCount++;
        $display("[TB] FAIL rsthold_early_edge%0d: got valid=%0b expected 0", e, code_valid);
      end
    end
    tick();
    compareCount++;
    if (code_valid !== 1'b1 || code_out !== 4'd7) begin
      mismatchCount++;
      $display("[TB] FAIL rsthold_requalify: got valid=%0b code=%0d expected 1/7", code_valid, code_out);
    end
    code_ready = 1'b1;
    tick();
    idleCycles(4);
  endtask

  task automatic test_err_saturation();
    int pulses;
    int lastPulse;
    code_ready = 1'b1;
    pulses     = 0;
    lastPulse  = 0;
    for (int ev = 0; ev < 256; ev++) begin
      onehot_in = 10'h005;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (invalid_pulse) begin
          pulses++;
          if (ev == 255) lastPulse++;
        end
      end
      idleCycles(4);
      if (ev == 254) begin
        compareCount++;
        if (err_count !== 8'd255) begin
          mismatchCount++;
          $display("[TB] FAIL sat_reach_255: got %0d expected 255", err_count);
        end
      end
    end
    compareCount++;
    if (err_count !== 8'd255) begin
      mismatchCount++;
      $display("[TB] FAIL sat_no_wrap: got %0d expected 255", err_count);
    end
    compareCount++;
    if (pulses != 256 || lastPulse != 1) begin
      mismatchCount++;
      $display("[TB] FAIL sat_pulses: got total=%0d last=%0d expected 256/1", pulses, lastPulse);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    onehot_in  = '0;
    code_ready = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_invalid();
    test_restart();
    test_reset_hold();
    test_err_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/onehot_to_binary.md
ONEHOT_TO_BINARY -- requirements
Module: onehot_to_binary

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock port clk, reset port rst_n.
REQ-002 Parameter: STABLE_CYCLES, default 4, number of consecutive identical synchronized samples required before a code is accepted (legal 2..255).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: onehot_in  input  10  asynchronous one-hot select lines; bit k denotes digit k.
REQ-006 Port: code_out  output  4  binary index of the accepted one-hot bit (0..9).
REQ-007 Port: code_valid  output  1  code_out is valid; held until accepted.
REQ-008 Port: code_ready  input  1  consumer accepts code_out when code_valid && code_ready at a rising edge.
REQ-009 Port: invalid_pulse  output  1  one-cycle pulse when a stable multi-hot pattern is rejected.
REQ-010 Port: err_count  output  8  saturating count of rejected patterns.

Function
REQ-011 onehot_in SHALL pass through a 2-flop synchronizer; all logic below uses the second stage (s2) only.
REQ-012 FSM states SHALL be IDLE, QUAL, HOLD, RELEASE; 8-bit stability counter cnt; 10-bit capture register cap.
REQ-013 IDLE: s2==0 -> stay; s2!=0 -> QUAL, cap<=s2, cnt<=1.
REQ-014 QUAL: s2==0 -> IDLE; s2!=cap (nonzero) -> stay, cap<=s2, cnt<=1; s2==cap and cnt<STABLE_CYCLES-1 -> cnt<=cnt+1.
REQ-015 QUAL, s2==cap and cnt==STABLE_CYCLES-1: if cap has exactly one bit set -> HOLD, code_out<=index, code_valid<=1; else -> RELEASE, invalid_pulse<=1 for one cycle, err_count<=err_count+1 saturating at 255.
REQ-016 Latency: a clean one-hot input held constant SHALL produce code_valid=1 after the (2+STABLE_CYCLES)th rising edge following its application.
REQ-017 HOLD: code_valid and code_out SHALL stay constant regardless of onehot_in until code_valid && code_ready; that edge -> RELEASE, code_valid<=0.
REQ-018 RELEASE: s2!=0 -> stay; s2==0 -> IDLE. A held input SHALL never generate a second code.
REQ-019 code_out SHALL retain the last accepted value outside HOLD.
REQ-020 An input that changes or drops before qualification SHALL produce neither code_valid nor invalid_pulse.
REQ-021 err_count SHALL not wrap; at 255 further rejections still pulse invalid_pulse.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, synchronizer stages 0, cnt 0, cap 0, code_out 0, code_valid 0, invalid_pulse 0, err_count 0.
REQ-023 Reset asserted mid-QUAL or mid-HOLD SHALL discard the pending code; no code_valid after deassertion until a fresh qualification completes.
REQ-024 Reset deassertion SHALL be synchronized to clk externally; first post-reset edge evaluates IDLE.

Structure
REQ-025 Shared package SHALL hold ONEHOT_W=10, CODE_W=4, the FSM state enumeration, and the one-hot-to-index function type.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff, parameterised by width, instantiated once at width 10.
REQ-027 Index encoding SHALL be combinational from cap; validity check = popcount(cap)==1.

Verification
REQ-028 STABLE_CYCLES=4, code_ready=1, onehot_in=10'h008 from edge 0 -> code_valid=1 after edge 6, code_out=3, single-cycle valid, no second code while input held.
REQ-029 onehot_in=10'h200 with code_ready=0 for 10 cycles then 1 -> code_out=9, code_valid held high all 10 cycles, drops the cycle after acceptance; input changes during HOLD ignored.
REQ-030 onehot_in=10'h005 held 8 cycles -> one invalid_pulse, err_count=1, code_valid never asserted; 256 such events -> err_count stays 255.
REQ-031 onehot_in=10'h002 for 2 cycles then 10'h010 held -> cnt restarts, code_out=4 only, no code 1 emitted.
REQ-032 rst_n pulsed low during HOLD with code_out=7 -> code_valid=0, code_out=0 immediately; input still 10'h080 after reset -> requalifies, code_out=7 after 2+STABLE_CYCLES edges.
